issue_ctrl: RTL and testbench

Issue controller between the decoder and the execution units. It holds one decoded instruction and tracks in-flight destination registers in a 32-entry scoreboard. It releases the instruction to its target unit only when source and destination hazards are clear and that unit is ready. CSR, mret/sret and illegal instructions are serialized: they issue only once every in-flight write has retired.

---
 rtl/issue_ctrl_pkg.sv | 35 +++
 rtl/issue_ctrl_if.sv | 45 ++++
 rtl/issue_ctrl_scoreboard.sv | 44 ++++
 rtl/issue_ctrl.sv | 97 +++++++++
 tb/tb_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared widths, entry record and FSM state encoding for the issue controller.
package issue_ctrl_pkg;

   localparam int XLEN            = 32;
   localparam int NB_UNIT         = 6;
   localparam int NB_OPERATION    = 6;
   localparam int ISSUE_PAYLOAD_W = 64;
   localparam int NB_REG          = 32;

   typedef logic [4:0] reg_adr_t;

   typedef struct packed {
      logic                       rd_v;
      reg_adr_t                   rd_adr;
      logic                       rs1_v;
      reg_adr_t                   rs1_adr;
      logic                       rs2_v;
      reg_adr_t                   rs2_adr;
      logic [NB_UNIT-1:0]         unit;
      logic [NB_OPERATION-1:0]    operation;
      logic                       serial;
      logic [ISSUE_PAYLOAD_W-1:0] payload;
   } issue_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } issue_state_t;

   function automatic logic [NB_REG-1:0] reg_onehot(input logic v, input reg_adr_t adr);
      return v ? (NB_REG'(1) << adr) : '0;
   endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decoder-to-controller and controller-to-execution handshake bundle.
interface issue_ctrl_if;
   import issue_ctrl_pkg::*;

   logic                       dec_valid_i;
   logic                       dec_ready_o;
   logic                       dec_rd_v_i;
   reg_adr_t                   dec_rd_adr_i;
   logic                       dec_rs1_v_i;
   reg_adr_t                   dec_rs1_adr_i;
   logic                       dec_rs2_v_i;
   reg_adr_t                   dec_rs2_adr_i;
   logic [NB_UNIT-1:0]         dec_unit_i;
   logic [NB_OPERATION-1:0]    dec_operation_i;
   logic                       dec_serial_i;
   logic [ISSUE_PAYLOAD_W-1:0] dec_payload_i;

   logic [NB_UNIT-1:0]         exe_unit_ready_i;
   logic                       exe_valid_o;
   logic [NB_UNIT-1:0]         exe_unit_o;
   logic [NB_OPERATION-1:0]    exe_operation_o;
   logic                       exe_rd_v_o;
   reg_adr_t                   exe_rd_adr_o;
   reg_adr_t                   exe_rs1_adr_o;
   reg_adr_t                   exe_rs2_adr_o;
   logic [ISSUE_PAYLOAD_W-1:0] exe_payload_o;

   // environment side: decoder and execution units
   modport master (
      output dec_valid_i, dec_rd_v_i, dec_rd_adr_i, dec_rs1_v_i, dec_rs1_adr_i,
             dec_rs2_v_i, dec_rs2_adr_i, dec_unit_i, dec_operation_i, dec_serial_i,
             dec_payload_i, exe_unit_ready_i,
      input  dec_ready_o, exe_valid_o, exe_unit_o, exe_operation_o, exe_rd_v_o,
             exe_rd_adr_o, exe_rs1_adr_o, exe_rs2_adr_o, exe_payload_o
   );

   modport slave (
      input  dec_valid_i, dec_rd_v_i, dec_rd_adr_i, dec_rs1_v_i, dec_rs1_adr_i,
             dec_rs2_v_i, dec_rs2_adr_i, dec_unit_i, dec_operation_i, dec_serial_i,
             dec_payload_i, exe_unit_ready_i,
      output dec_ready_o, exe_valid_o, exe_unit_o, exe_operation_o, exe_rd_v_o,
             exe_rd_adr_o, exe_rs1_adr_o, exe_rs2_adr_o, exe_payload_o
   );

endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// In-flight destination scoreboard with same-cycle writeback bypass and hazard compare.
module issue_ctrl_scoreboard
   import issue_ctrl_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     set_v,
   input  reg_adr_t set_adr,
   input  logic     wbk_v,
   input  reg_adr_t wbk_adr,
   input  logic     rs1_v,
   input  reg_adr_t rs1_adr,
   input  logic     rs2_v,
   input  reg_adr_t rs2_adr,
   input  logic     rd_v,
   input  reg_adr_t rd_adr,
   output logic     hazard,
   output logic     eff_zero,
   output logic     any_pending
);

   logic [NB_REG-1:0] pending;
   logic [NB_REG-1:0] pending_eff;
   logic [NB_REG-1:0] set_mask;
   logic [NB_REG-1:0] clr_mask;

   always_comb begin
      clr_mask    = reg_onehot(wbk_v, wbk_adr);
      set_mask    = reg_onehot(set_v, set_adr) & ~NB_REG'(1);
      pending_eff = pending & ~clr_mask;
      hazard      = (rs1_v & pending_eff[rs1_adr])
                  | (rs2_v & pending_eff[rs2_adr])
                  | (rd_v  & pending_eff[rd_adr]);
      eff_zero    = (pending_eff == '0);
      any_pending = |pending;
   end

   // set after clear so an issue and a writeback to the same register leave it pending
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending_eff | set_mask) & ~NB_REG'(1);
   end

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue stage: holds one decoded instruction and releases it when hazards clear.
//   state    | meaning
//   ST_EMPTY | no instruction held
//   ST_HOLD  | instruction held, waiting for operands/unit or issuing
//   ST_DRAIN | serial instruction held, waiting for all in-flight writes
module issue_ctrl
   import issue_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   issue_ctrl_if.slave    bus,
   input  logic           wbk_v_i,
   input  reg_adr_t       wbk_adr_i,
   input  logic           flush_i,
   output logic           busy_o
);

   issue_state_t state;
   issue_entry_t entry;
   issue_entry_t new_entry;
   logic         entry_v;
   logic         unit_rdy;
   logic         hazard;
   logic         eff_zero;
   logic         any_pending;
   logic         issue;
   logic         dec_ready;
   logic         capture;

   always_comb begin
      new_entry           = '0;
      new_entry.rd_v      = bus.dec_rd_v_i;
      new_entry.rd_adr    = bus.dec_rd_adr_i;
      new_entry.rs1_v     = bus.dec_rs1_v_i;
      new_entry.rs1_adr   = bus.dec_rs1_adr_i;
      new_entry.rs2_v     = bus.dec_rs2_v_i;
      new_entry.rs2_adr   = bus.dec_rs2_adr_i;
      new_entry.unit      = bus.dec_unit_i;
      new_entry.operation = bus.dec_operation_i;
      new_entry.serial    = bus.dec_serial_i;
      new_entry.payload   = bus.dec_payload_i;
   end

   always_comb begin
      entry_v   = (state != ST_EMPTY);
      unit_rdy  = (entry.unit == '0) | (|(entry.unit & bus.exe_unit_ready_i));
      issue     = entry_v & ~flush_i & ~hazard & unit_rdy & (~entry.serial | eff_zero);
      dec_ready = ~rst & ~flush_i & (~entry_v | issue);
      capture   = bus.dec_valid_i & dec_ready;
   end

   issue_ctrl_scoreboard u_sb (
      .clk         (clk),
      .rst         (rst),
      .set_v       (issue & entry.rd_v),
      .set_adr     (entry.rd_adr),
      .wbk_v       (wbk_v_i),
      .wbk_adr     (wbk_adr_i),
      .rs1_v       (entry.rs1_v),
      .rs1_adr     (entry.rs1_adr),
      .rs2_v       (entry.rs2_v),
      .rs2_adr     (entry.rs2_adr),
      .rd_v        (entry.rd_v),
      .rd_adr      (entry.rd_adr),
      .hazard      (hazard),
      .eff_zero    (eff_zero),
      .any_pending (any_pending)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_EMPTY;
         entry <= '0;
      end else if (flush_i) begin
         state <= ST_EMPTY;
      end else if (capture) begin
         entry <= new_entry;
         state <= bus.dec_serial_i ? ST_DRAIN : ST_HOLD;
      end else if (issue) begin
         state <= ST_EMPTY;
      end else if (entry_v) begin
         state <= entry.serial ? ST_DRAIN : ST_HOLD;
      end
   end

   assign bus.dec_ready_o     = dec_ready;
   assign bus.exe_valid_o     = issue;
   assign bus.exe_unit_o      = entry.unit;
   assign bus.exe_operation_o = entry.operation;
   assign bus.exe_rd_v_o      = entry.rd_v;
   assign bus.exe_rd_adr_o    = entry.rd_adr;
   assign bus.exe_rs1_adr_o   = entry.rs1_adr;
   assign bus.exe_rs2_adr_o   = entry.rs2_adr;
   assign bus.exe_payload_o   = entry.payload;
   assign busy_o              = entry_v | any_pending;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: per-cycle vector table plus backpressure and reset sequences.
module tb_issue_ctrl;
   import issue_ctrl_pkg::*;

   localparam logic [5:0] U_ALU = 6'b000001;
   localparam logic [5:0] U_MUL = 6'b000010;
   localparam logic [5:0] U_DIV = 6'b000100;
   localparam logic [5:0] U_LSU = 6'b001000;
   localparam logic [5:0] U_BR  = 6'b010000;
   localparam logic [5:0] U_CSR = 6'b100000;

   logic     clk = 1'b0;
   logic     rst;
   logic     wbk_v_i;
   reg_adr_t wbk_adr_i;
   logic     flush_i;
   logic     busy_o;

   int checks = 0;
   int errors = 0;

   issue_ctrl_if bus ();

   issue_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .wbk_v_i   (wbk_v_i),
      .wbk_adr_i (wbk_adr_i),
      .flush_i   (flush_i),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       dv;
      logic       rdv;
      logic [4:0] rd;
      logic       r1v;
      logic [4:0] r1;
      logic       r2v;
      logic [4:0] r2;
      logic [5:0] unit;
      logic       ser;
      logic       wv;
      logic [4:0] wa;
      logic       fl;
      logic       ev;
      logic       dr;
      logic [4:0] erd;
      logic       bsy;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic dv, input logic rdv, input logic [4:0] rd,
                               input logic r1v, input logic [4:0] r1,
                               input logic r2v, input logic [4:0] r2,
                               input logic [5:0] unit, input logic ser,
                               input logic wv, input logic [4:0] wa, input logic fl,
                               input logic ev, input logic dr, input logic [4:0] erd,
                               input logic bsy);
      vec_t v;
      v.dv = dv; v.rdv = rdv; v.rd = rd; v.r1v = r1v; v.r1 = r1; v.r2v = r2v; v.r2 = r2;
      v.unit = unit; v.ser = ser; v.wv = wv; v.wa = wa; v.fl = fl;
      v.ev = ev; v.dr = dr; v.erd = erd; v.bsy = bsy;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_dec(input logic dv, input logic rdv, input logic [4:0] rd,
                            input logic r1v, input logic [4:0] r1,
                            input logic r2v, input logic [4:0] r2,
                            input logic [5:0] unit, input logic ser,
                            input logic [5:0] op, input logic [63:0] pay);
      bus.dec_valid_i     = dv;
      bus.dec_rd_v_i      = rdv;
      bus.dec_rd_adr_i    = rd;
      bus.dec_rs1_v_i     = r1v;
      bus.dec_rs1_adr_i   = r1;
      bus.dec_rs2_v_i     = r2v;
      bus.dec_rs2_adr_i   = r2;
      bus.dec_unit_i      = unit;
      bus.dec_serial_i    = ser;
      bus.dec_operation_i = op;
      bus.dec_payload_i   = pay;
   endtask

   initial begin
      rst = 1'b1;
      flush_i = 1'b0;
      wbk_v_i = 1'b0;
      wbk_adr_i = '0;
      bus.exe_unit_ready_i = 6'h3f;
      drive_dec(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, U_ALU, 1'b0, 6'd0, 64'd0);

      // independent stream
      vq.push_back(mk(1,1, 1, 1, 0,0, 0,U_ALU,0, 0, 0,0, 0,1, 0,0));
      vq.push_back(mk(1,1, 2, 1, 0,0, 0,U_ALU,0, 0, 0,0, 1,1, 1,1));
      vq.push_back(mk(1,1, 3, 1, 4,1, 5,U_ALU,0, 0, 0,0, 1,1, 2,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 1,1, 3,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1, 1,0, 0,1, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1, 2,0, 0,1, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1, 3,0, 0,1, 0,1));
      // RAW on x5, then WAW on x8
      vq.push_back(mk(1,1, 5, 1, 1,0, 0,U_MUL,0, 0, 0,0, 0,1, 0,0));
      vq.push_back(mk(1,1, 6, 1, 5,1, 7,U_ALU,0, 0, 0,0, 1,1, 5,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 0,0, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 0,0, 0,1));
      vq.push_back(mk(1,1, 8, 1, 1,0, 0,U_DIV,0, 1, 5,0, 1,1, 6,1));
      vq.push_back(mk(1,1, 8, 1, 0,0, 0,U_ALU,0, 0, 0,0, 1,1, 8,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 0,0, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1, 6,0, 0,0, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1, 8,0, 1,1, 8,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1, 8,0, 0,1, 0,1));
      // serialization behind two loads
      vq.push_back(mk(1,1,10, 1, 0,0, 0,U_LSU,0, 0, 0,0, 0,1, 0,0));
      vq.push_back(mk(1,1,11, 1, 0,0, 0,U_LSU,0, 0, 0,0, 1,1,10,1));
      vq.push_back(mk(1,1,12, 1,13,0, 0,U_CSR,1, 0, 0,0, 1,1,11,1));
      vq.push_back(mk(1,1,14, 1, 0,0, 0,U_ALU,0, 0, 0,0, 0,0, 0,1));
      vq.push_back(mk(1,1,14, 1, 0,0, 0,U_ALU,0, 1,10,0, 0,0, 0,1));
      vq.push_back(mk(1,1,14, 1, 0,0, 0,U_ALU,0, 1,11,0, 1,1,12,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 1,1,14,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1,12,0, 0,1, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1,14,0, 0,1, 0,1));
      // flush of a stalled entry keeps x16 pending
      vq.push_back(mk(1,1,16, 0, 0,0, 0,U_MUL,0, 0, 0,0, 0,1, 0,0));
      vq.push_back(mk(1,1,15, 1,16,0, 0,U_ALU,0, 0, 0,0, 1,1,16,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 0,0, 0,1));
      vq.push_back(mk(1,1,20, 0, 0,0, 0,U_ALU,0, 0, 0,1, 0,0, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 0,1, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1,16,0, 0,1, 0,1));
      // x0 never becomes pending
      vq.push_back(mk(1,1, 0, 1, 0,0, 0,U_ALU,0, 0, 0,0, 0,1, 0,0));
      vq.push_back(mk(1,1,17, 1, 0,1, 0,U_ALU,0, 0, 0,0, 1,1, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 1,1,17,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1,17,0, 0,1, 0,1));
      // set and clear of x9 in the same cycle: set wins
      vq.push_back(mk(1,1, 9, 0, 0,0, 0,U_ALU,0, 0, 0,0, 0,1, 0,0));
      vq.push_back(mk(1,1,18, 1, 9,0, 0,U_ALU,0, 1, 9,0, 1,1, 9,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 0,0, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1, 9,0, 1,1,18,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 1,18,0, 0,1, 0,1));
      vq.push_back(mk(0,0, 0, 0, 0,0, 0,U_ALU,0, 0, 0,0, 0,1, 0,0));

      // reset state
      @(negedge clk); #2;
      chk("rst_dec_ready", 64'(bus.dec_ready_o), 64'd0);
      chk("rst_exe_valid", 64'(bus.exe_valid_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      drive_dec(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 6'd0, 64'd0);
      #2;
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_ready_after", 64'(bus.dec_ready_o), 64'd1);
      chk("rst_exe_unit", 64'(bus.exe_unit_o), 64'd0);
      chk("rst_exe_rd", 64'(bus.exe_rd_adr_o), 64'd0);
      chk("rst_exe_payload", bus.exe_payload_o, 64'd0);

      // per-cycle vector table
      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive_dec(vq[i].dv, vq[i].rdv, vq[i].rd, vq[i].r1v, vq[i].r1, vq[i].r2v, vq[i].r2,
                   vq[i].unit, vq[i].ser, 6'(vq[i].rd), 64'(vq[i].rd));
         wbk_v_i   = vq[i].wv;
         wbk_adr_i = vq[i].wa;
         flush_i   = vq[i].fl;
         bus.exe_unit_ready_i = 6'h3f;
         #2;
         chk($sformatf("exe_valid[%0d]", i), 64'(bus.exe_valid_o), 64'(vq[i].ev));
         chk($sformatf("dec_ready[%0d]", i), 64'(bus.dec_ready_o), 64'(vq[i].dr));
         chk($sformatf("busy[%0d]", i), 64'(busy_o), 64'(vq[i].bsy));
         if (vq[i].ev)
            chk($sformatf("exe_rd[%0d]", i), 64'(bus.exe_rd_adr_o), 64'(vq[i].erd));
      end

      // branch unit backpressure for four cycles
      @(negedge clk);
      wbk_v_i = 1'b0;
      flush_i = 1'b0;
      bus.exe_unit_ready_i = 6'h3f & ~U_BR;
      drive_dec(1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 5'd2, U_BR, 1'b0, 6'h15, 64'hDEAD_BEEF_0123_4567);
      #2;
      chk("bp_capture_ready", 64'(bus.dec_ready_o), 64'd1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.dec_valid_i = 1'b0;
         #2;
         chk($sformatf("bp_valid[%0d]", c), 64'(bus.exe_valid_o), 64'd0);
         chk($sformatf("bp_ready[%0d]", c), 64'(bus.dec_ready_o), 64'd0);
         chk($sformatf("bp_unit[%0d]", c), 64'(bus.exe_unit_o), 64'(U_BR));
         chk($sformatf("bp_payload[%0d]", c), bus.exe_payload_o, 64'hDEAD_BEEF_0123_4567);
         chk($sformatf("bp_rs[%0d]", c), 64'({bus.exe_rs1_adr_o, bus.exe_rs2_adr_o}), 64'({5'd1, 5'd2}));
      end
      @(negedge clk);
      bus.exe_unit_ready_i = 6'h3f;
      #2;
      chk("bp_issue", 64'(bus.exe_valid_o), 64'd1);
      chk("bp_operation", 64'(bus.exe_operation_o), 64'h15);
      chk("bp_rd_v", 64'(bus.exe_rd_v_o), 64'd0);

      // no-unit instruction issues with every unit stalled
      @(negedge clk);
      bus.exe_unit_ready_i = 6'h00;
      drive_dec(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 6'h00, 1'b0, 6'h01, 64'd7);
      #2;
      chk("nounit_idle", 64'(bus.exe_valid_o), 64'd0);
      @(negedge clk);
      bus.dec_valid_i = 1'b0;
      #2;
      chk("nounit_issue", 64'(bus.exe_valid_o), 64'd1);
      chk("nounit_rd", 64'(bus.exe_rd_adr_o), 64'd3);
      @(negedge clk);
      bus.exe_unit_ready_i = 6'h3f;
      wbk_v_i = 1'b1;
      wbk_adr_i = 5'd3;
      #2;
      chk("nounit_done", 64'(bus.exe_valid_o), 64'd0);

      // reset while an entry stalls on x20
      @(negedge clk);
      wbk_v_i = 1'b0;
      drive_dec(1'b1, 1'b1, 5'd20, 1'b0, 5'd0, 1'b0, 5'd0, U_MUL, 1'b0, 6'h02, 64'h1111);
      @(negedge clk);
      drive_dec(1'b1, 1'b1, 5'd21, 1'b1, 5'd20, 1'b0, 5'd0, U_ALU, 1'b0, 6'h03, 64'h2222);
      #2;
      chk("mid_issue_mul", 64'(bus.exe_valid_o), 64'd1);
      @(negedge clk);
      bus.dec_valid_i = 1'b0;
      #2;
      chk("mid_stall", 64'(bus.exe_valid_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk("mid_rst_ready", 64'(bus.dec_ready_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("mid_busy", 64'(busy_o), 64'd0);
      chk("mid_valid", 64'(bus.exe_valid_o), 64'd0);
      chk("mid_payload", bus.exe_payload_o, 64'd0);
      chk("mid_ready", 64'(bus.dec_ready_o), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
